// File: rtl/dmux_pkg.sv
// Shared helpers for the streaming demultiplexer: select-width sizing and
// channel lane indexing into the flattened out_data bus.
package dmux_pkg;

   function automatic int clog2_min1(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

   function automatic int ch_lsb(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry output register for a single demux channel: data plus valid.
// A load wins over a simultaneous drain, so a slot can be refilled as it empties.
module dmux_slot
   import dmux_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit ZERO_IDLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
         if (ZERO_IDLE) q <= '0;
      end
   end

endmodule

// File: rtl/dmux_stream.sv
// N-way streaming demultiplexer with per-channel registered slots, broadcast
// support and a saturating counter of words dropped for out-of-range selects.
module dmux_stream
   import dmux_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NCH       = 4,
   parameter bit ZERO_IDLE = 1'b1,
   parameter int CNTW      = 8,
   localparam int SELW     = clog2_min1(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SELW-1:0]      in_sel,
   input  logic                 in_bcast,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic [CNTW-1:0]      drop_cnt
);

   logic [NCH-1:0] free;
   logic [NCH-1:0] sel_match;
   logic [NCH-1:0] load;
   logic [NCH-1:0] drain;
   logic           sel_ok;
   logic           accept;
   logic           drop;

   assign free  = ~out_valid | out_ready;
   assign drain = out_valid & out_ready;

   always_comb begin
      sel_match = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_match[i] = (in_sel == SELW'(i));
      end
   end

   assign sel_ok = |sel_match;

   // in_ready never looks at in_valid; reset forces it low.
   always_comb begin
      in_ready = 1'b0;
      if (!rst_n)        in_ready = 1'b0;
      else if (in_bcast) in_ready = &free;
      else if (sel_ok)   in_ready = |(sel_match & free);
      else               in_ready = 1'b1;
   end

   assign accept = in_valid && in_ready;
   assign drop   = accept && !in_bcast && !sel_ok;

   always_comb begin
      load = '0;
      if (accept) begin
         if (in_bcast) load = '1;
         else          load = sel_match;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (drop && (drop_cnt != {CNTW{1'b1}}))
         drop_cnt <= drop_cnt + 1'b1;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_slot
      dmux_slot #(
         .WIDTH     (WIDTH),
         .ZERO_IDLE (ZERO_IDLE)
      ) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[g]),
         .drain (drain[g]),
         .d     (in_data),
         .q     (out_data[ch_lsb(g, WIDTH) +: WIDTH]),
         .valid (out_valid[g])
      );
   end

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: a default 4-channel build, a 3-channel build
// for out-of-range selects, and a hold-last-word build for idle data.
module tb_dmux_stream;

   logic clk;
   logic rst_n;

   logic [15:0] a_data;
   logic [1:0]  a_sel;
   logic        a_bcast, a_valid, a_ready;
   logic [63:0] a_odata;
   logic [3:0]  a_ovalid, a_oready;
   logic [7:0]  a_drop;

   logic [15:0] b_data;
   logic [1:0]  b_sel;
   logic        b_bcast, b_valid, b_ready;
   logic [47:0] b_odata;
   logic [2:0]  b_ovalid, b_oready;
   logic [7:0]  b_drop;

   logic [15:0] c_data;
   logic [1:0]  c_sel;
   logic        c_bcast, c_valid, c_ready;
   logic [63:0] c_odata;
   logic [3:0]  c_ovalid, c_oready;
   logic [7:0]  c_drop;

   int n_cmp = 0;
   int n_err = 0;

   dmux_stream #(.WIDTH(16), .NCH(4), .ZERO_IDLE(1'b1), .CNTW(8)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel),
      .in_bcast(a_bcast), .in_valid(a_valid), .in_ready(a_ready),
      .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready),
      .drop_cnt(a_drop));

   dmux_stream #(.WIDTH(16), .NCH(3), .ZERO_IDLE(1'b1), .CNTW(8)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel),
      .in_bcast(b_bcast), .in_valid(b_valid), .in_ready(b_ready),
      .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready),
      .drop_cnt(b_drop));

   dmux_stream #(.WIDTH(16), .NCH(4), .ZERO_IDLE(1'b0), .CNTW(8)) u_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel),
      .in_bcast(c_bcast), .in_valid(c_valid), .in_ready(c_ready),
      .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_oready),
      .drop_cnt(c_drop));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Producer must hold its word stable while it waits for in_ready.
   logic        a_pend = 1'b0;
   logic [18:0] a_held = '0;
   always @(posedge clk) begin
      if (rst_n && a_pend && a_valid) begin
         n_cmp++;
         assert ({a_data, a_sel, a_bcast} === a_held) else begin
            n_err++;
            $error("FAIL producer_hold: observed %h expected %h", {a_data, a_sel, a_bcast}, a_held);
         end
      end
      a_pend = rst_n && a_valid && !a_ready;
      a_held = {a_data, a_sel, a_bcast};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_data = '0; a_sel = '0; a_bcast = 1'b0; a_valid = 1'b0; a_oready = '0;
      b_data = '0; b_sel = '0; b_bcast = 1'b0; b_valid = 1'b0; b_oready = '0;
      c_data = '0; c_sel = '0; c_bcast = 1'b0; c_valid = 1'b0; c_oready = '0;
      #12;
      chk("rst_ready_low", 64'(a_ready), 64'h0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ovalid", 64'(a_ovalid), 64'h0);
      chk("post_rst_odata", a_odata, 64'h0);
      chk("post_rst_drop", 64'(b_drop), 64'h0);

      // Unicast to ch2, then ch2 busy, then ch1
      tick();
      a_data = 16'hA5A5; a_sel = 2'd2; a_valid = 1'b1; #1;
      chk("uni_ready", 64'(a_ready), 64'h1);
      tick();
      a_valid = 1'b0; #1;
      chk("uni_ovalid", 64'(a_ovalid), 64'h4);
      chk("uni_ch2", 64'(a_odata[47:32]), 64'hA5A5);
      a_data = 16'h5555; a_sel = 2'd2; a_valid = 1'b1; #1;
      chk("uni_busy_ready", 64'(a_ready), 64'h0);
      a_valid = 1'b0; #1;
      a_data = 16'h1111; a_sel = 2'd1; a_valid = 1'b1; #1;
      chk("uni_ch1_ready", 64'(a_ready), 64'h1);
      tick();
      a_valid = 1'b0; #1;
      chk("uni_ch1_ovalid", 64'(a_ovalid), 64'h6);
      chk("uni_ch1_data", 64'(a_odata[31:16]), 64'h1111);

      // Drain and reload ch2 in one cycle
      a_data = 16'h1234; a_sel = 2'd2; a_valid = 1'b1; a_oready = 4'b0100; #1;
      chk("reload_ready", 64'(a_ready), 64'h1);
      tick();
      a_valid = 1'b0; a_oready = 4'b0000; #1;
      chk("reload_ch2", 64'(a_odata[47:32]), 64'h1234);
      chk("reload_ovalid", 64'(a_ovalid), 64'h6);
      chk("reload_ch1_kept", 64'(a_odata[31:16]), 64'h1111);

      // Fill ch3, then broadcast with ch3 stalled
      a_data = 16'h3333; a_sel = 2'd3; a_valid = 1'b1; #1;
      tick();
      a_valid = 1'b0; #1;
      chk("fill_ch3_ovalid", 64'(a_ovalid), 64'he);
      a_data = 16'hBEEF; a_bcast = 1'b1; a_sel = 2'd0; a_valid = 1'b1; a_oready = 4'b0111; #1;
      chk("bc_stall_ready", 64'(a_ready), 64'h0);
      tick();
      chk("bc_drained_ovalid", 64'(a_ovalid), 64'h8);
      chk("bc_ch1_zeroed", 64'(a_odata[31:16]), 64'h0);
      chk("bc_still_stalled", 64'(a_ready), 64'h0);
      a_oready = 4'b1000; #1;
      chk("bc_ready", 64'(a_ready), 64'h1);
      tick();
      a_valid = 1'b0; a_bcast = 1'b0; a_oready = 4'b0000; #1;
      chk("bc_ovalid", 64'(a_ovalid), 64'hf);
      chk("bc_odata", a_odata, 64'hBEEF_BEEF_BEEF_BEEF);
      chk("bc_no_drop", 64'(a_drop), 64'h0);

      // Hold-last-word build keeps idle data
      c_data = 16'h00FF; c_sel = 2'd0; c_valid = 1'b1; #1;
      tick();
      c_valid = 1'b0; c_oready = 4'b0001; #1;
      chk("zi0_loaded", 64'(c_odata[15:0]), 64'h00FF);
      tick();
      c_oready = 4'b0000; #1;
      chk("zi0_ovalid", 64'(c_ovalid), 64'h0);
      chk("zi0_ch0_hold", 64'(c_odata[15:0]), 64'h00FF);

      // Broadcast with an out-of-range select is not counted
      b_data = 16'hCAFE; b_sel = 2'd3; b_bcast = 1'b1; b_valid = 1'b1; #1;
      chk("b_bc_ready", 64'(b_ready), 64'h1);
      tick();
      b_valid = 1'b0; b_bcast = 1'b0; b_oready = 3'b111; #1;
      chk("b_bc_ovalid", 64'(b_ovalid), 64'h7);
      chk("b_bc_drop", 64'(b_drop), 64'h0);
      tick();
      b_oready = 3'b000; #1;
      chk("b_drained", 64'(b_ovalid), 64'h0);

      // 300 words to sel=3 on the 3-channel build
      b_data = 16'h7777; b_sel = 2'd3; b_valid = 1'b1; #1;
      for (int i = 0; i < 300; i++) begin
         chk("bad_sel_ready", 64'(b_ready), 64'h1);
         tick();
         if (i == 0) chk("drop_first", 64'(b_drop), 64'h1);
         if (i == 254) chk("drop_at_max", 64'(b_drop), 64'hff);
      end
      b_valid = 1'b0; #1;
      chk("drop_sat", 64'(b_drop), 64'hff);
      chk("bad_sel_ovalid", 64'(b_ovalid), 64'h0);
      chk("bad_sel_odata", b_odata, 64'h0);

      // Asynchronous reset mid-run with slots full
      chk("pre_rst_full", 64'(a_ovalid), 64'hf);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_ovalid", 64'(a_ovalid), 64'h0);
      chk("arst_odata", a_odata, 64'h0);
      chk("arst_drop", 64'(b_drop), 64'h0);
      chk("arst_ready", 64'(a_ready), 64'h0);
      chk("arst_c_odata", c_odata, 64'h0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
